// File: rtl/posit8_pkg.sv
// Shared constants and the stage-1 payload layout for the 8-bit posit (es=0) encoder.
package posit8_pkg;

  localparam int POSIT_N  = 8;
  localparam int EXP_BIAS = 6;
  localparam int EXP_MAX  = 12;

  localparam logic [6:0] MAXPOS_MAG = 7'h7F;
  localparam logic [7:0] NAR_BITS   = 8'h80;
  localparam logic [7:0] ZERO_BITS  = 8'h00;

  // Everything stage 2 needs to finish the encode: the truncated body,
  // the rounding bits below it, and the special-value flags.
  typedef struct packed {
    logic [6:0] body;
    logic       guard;
    logic       sticky;
    logic       sign;
    logic       zero;
    logic       nar;
  } s1_payload_t;

endpackage

// File: rtl/posit8_round_pack.sv
// Combinational round/pack: RNE on the body bit string, saturation at maxpos,
// two's-complement negation and special-value override.
module posit8_round_pack
  import posit8_pkg::*;
#(
  parameter int BODY_W = 7
) (
  input  logic [BODY_W-1:0] body,
  input  logic              guard,
  input  logic              sticky,
  input  logic              sign,
  input  logic              zero,
  input  logic              nar,
  output logic [BODY_W:0]   posit
);

  localparam logic [BODY_W-1:0] MAG_ALL_ONES = {BODY_W{1'b1}};

  logic              up;
  logic [BODY_W-1:0] mag;
  logic [BODY_W:0]   pos_bits;

  // Round to nearest even; an all-ones body is maxpos and must not wrap into NaR.
  always_comb begin
    up       = guard & (sticky | body[0]);
    mag      = body;
    pos_bits = '0;
    posit    = '0;
    if (body != MAG_ALL_ONES) begin
      mag = body + {{(BODY_W-1){1'b0}}, up};
    end
    pos_bits = {1'b0, mag};
    posit    = sign ? (~pos_bits + 1'b1) : pos_bits;
    if (nar) begin
      posit = {1'b1, {BODY_W{1'b0}}};
    end else if (zero) begin
      posit = '0;
    end
  end

endmodule

// File: rtl/posit8_encoder_pipe.sv
// Two-stage posit8 (es=0) encoder. Stage 1 builds the regime/body and the
// rounding bits from the biased exponent; stage 2 rounds, negates and registers
// the final bit string. Valid/ready on both sides, one beat per cycle.
module posit8_encoder_pipe
  import posit8_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [3:0]           in_exp,
  input  logic [FRAC_W-1:0]    in_frac,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_nar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POSIT_N-1:0]   out_posit
);

  localparam logic [3:0] BIAS4    = 4'(EXP_BIAS);
  localparam logic [3:0] EXP_MAX4 = 4'(EXP_MAX);
  localparam int         PW       = 7 + FRAC_W;

  s1_payload_t        s1_next;
  s1_payload_t        s1_q;
  logic               s1_valid;
  logic               s2_valid;
  logic               s2_advance;
  logic [POSIT_N-1:0] posit_next;
  logic [POSIT_N-1:0] posit_q;

  logic [2:0]         run;
  logic [2:0]         shamt;
  logic [6:0]         regime;
  logic [PW-1:0]      placed;

  assign s2_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s2_advance;
  assign out_valid  = s2_valid;
  assign out_posit  = posit_q;

  // Stage 1: place the fraction just below the regime, OR the regime pattern
  // on top, then split into 7-bit body, guard and sticky.
  // Positive scale: (s+1) ones then a zero, shift = 11 - exp.
  // Negative scale: (-s) zeros then a one, shift = exp.
  always_comb begin
    run     = '0;
    shamt   = '0;
    regime  = '0;
    placed  = '0;
    s1_next = '0;
    if (in_exp >= BIAS4) begin
      run    = 3'(in_exp - 4'd5);
      shamt  = 3'(4'd11 - in_exp);
      regime = ~(7'h7F >> run);
    end else begin
      run    = 3'(BIAS4 - in_exp);
      shamt  = 3'(in_exp);
      regime = 7'h40 >> run;
    end
    placed         = {7'b0, in_frac} << shamt;
    s1_next.body   = placed[PW-1 -: 7] | regime;
    s1_next.guard  = placed[FRAC_W-1];
    s1_next.sticky = (|placed[FRAC_W-2:0]) | in_sticky;
    if (in_exp >= EXP_MAX4) begin
      s1_next.body   = MAXPOS_MAG;
      s1_next.guard  = 1'b0;
      s1_next.sticky = 1'b0;
    end
    s1_next.sign = in_sign;
    s1_next.zero = in_zero;
    s1_next.nar  = in_nar;
  end

  // Stage 1 register: accepts a beat whenever it is empty or draining into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_next;
      end
    end
  end

  posit8_round_pack #(
    .BODY_W (7)
  ) u_round_pack (
    .body   (s1_q.body),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .sign   (s1_q.sign),
    .zero   (s1_q.zero),
    .nar    (s1_q.nar),
    .posit  (posit_next)
  );

  // Stage 2 register: holds the output beat stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      posit_q  <= ZERO_BITS;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        posit_q <= posit_next;
      end
    end
  end

endmodule

// File: tb/tb_posit8_encoder_pipe.sv
// Self-checking bench for posit8_encoder_pipe: directed vector table, latency
// and reset sequences, and a randomized backpressure stream against a model.
module tb_posit8_encoder_pipe;

  localparam int FRAC_W = 8;
  localparam int N_TBL  = 20;
  localparam int N_RAND = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [3:0]        in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              in_sticky;
  logic              in_zero;
  logic              in_nar;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_posit;

  posit8_encoder_pipe #(.FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              sign;
    logic [3:0]        exp;
    logic [FRAC_W-1:0] frac;
    logic              sticky;
    logic              zero;
    logic              nar;
    logic [7:0]        want;
  } vec_t;

  vec_t       tbl [N_TBL];
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  bit         in_fire;
  bit         out_fire;
  int         cmp_cnt = 0;
  int         mis_cnt = 0;

  // Reference: write the regime and fraction out as a list of bits, take the
  // first seven as the body and round to nearest even on what is left.
  function automatic logic [7:0] ref_encode(logic sg, logic [3:0] e, logic [FRAC_W-1:0] f,
                                            logic st, logic z, logic n);
    int bits[$];
    int s;
    int mag;
    int g;
    int stk;
    if (n) return 8'h80;
    if (z) return 8'h00;
    if (e >= 4'd12) begin
      mag = 127;
    end else begin
      s = int'(e) - 6;
      if (s >= 0) begin
        for (int i = 0; i < s + 1; i++) bits.push_back(1);
        bits.push_back(0);
      end else begin
        for (int i = 0; i < -s; i++) bits.push_back(0);
        bits.push_back(1);
      end
      for (int i = FRAC_W - 1; i >= 0; i--) bits.push_back(int'(f[i]));
      mag = 0;
      for (int i = 0; i < 7; i++) mag = mag * 2 + bits[i];
      g   = bits[7];
      stk = int'(st);
      for (int i = 8; i < bits.size(); i++) stk = stk | bits[i];
      if (mag != 127 && g == 1 && (stk == 1 || (mag % 2) == 1)) mag = mag + 1;
    end
    return sg ? 8'(256 - mag) : 8'(mag);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    cmp_cnt++;
    if (act !== req) begin
      mis_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: inputs were set just after a negedge; sample handshakes before
  // the posedge, score them, then move to the next negedge.
  task automatic tick();
    logic [7:0] want;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    check("in_ready", {7'b0, in_ready}, {7'b0, !(exp_q.size() >= 2 && !out_ready)});
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_posit, 8'hxx);
      end else begin
        want = exp_q.pop_front();
        check("out_posit", out_posit, want);
      end
    end
    if (in_fire) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic set_beat(input logic sg, input logic [3:0] e, input logic [FRAC_W-1:0] f,
                          input logic st, input logic z, input logic n);
    in_sign   = sg;
    in_exp    = e;
    in_frac   = f;
    in_sticky = st;
    in_zero   = z;
    in_nar    = n;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    check(name, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    int  sent;
    bit  have;
    logic [7:0] last_cur;

    tbl[0]  = '{1'b0, 4'd6,  8'h00, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[1]  = '{1'b0, 4'd6,  8'h80, 1'b0, 1'b0, 1'b0, 8'h50};
    tbl[2]  = '{1'b1, 4'd6,  8'h00, 1'b0, 1'b0, 1'b0, 8'hC0};
    tbl[3]  = '{1'b0, 4'd7,  8'h00, 1'b0, 1'b0, 1'b0, 8'h60};
    tbl[4]  = '{1'b0, 4'd6,  8'h04, 1'b0, 1'b0, 1'b0, 8'h40};
    tbl[5]  = '{1'b0, 4'd6,  8'h0C, 1'b0, 1'b0, 1'b0, 8'h42};
    tbl[6]  = '{1'b0, 4'd6,  8'h04, 1'b1, 1'b0, 1'b0, 8'h41};
    tbl[7]  = '{1'b0, 4'd12, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F};
    tbl[8]  = '{1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F};
    tbl[9]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[10] = '{1'b1, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 8'hFF};
    tbl[11] = '{1'b0, 4'd11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h7F};
    tbl[12] = '{1'b0, 4'd6,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 4'd9,  8'hAB, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 4'd6,  8'h00, 1'b0, 1'b1, 1'b1, 8'h80};
    tbl[15] = '{1'b1, 4'd3,  8'h55, 1'b0, 1'b0, 1'b1, 8'h80};
    tbl[16] = '{1'b1, 4'd13, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81};
    tbl[17] = '{1'b0, 4'd5,  8'h00, 1'b0, 1'b0, 1'b0, 8'h20};
    tbl[18] = '{1'b0, 4'd0,  8'h80, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[19] = '{1'b0, 4'd8,  8'hF0, 1'b0, 1'b0, 1'b0, 8'h78};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cur_exp   = 8'h00;
    set_beat(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_out_valid", {7'b0, out_valid}, 8'd0);
    check("reset_out_posit", out_posit, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: one beat in, nothing after one edge, result after the second.
    set_beat(1'b0, 4'd6, 8'h00, 1'b0, 1'b0, 1'b0);
    cur_exp  = 8'h40;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("latency_edge1_valid", {7'b0, out_valid}, 8'd0);
    tick();
    #1;
    check("latency_edge2_valid", {7'b0, out_valid}, 8'd1);
    tick();
    check("latency_drained", 8'(exp_q.size()), 8'd0);

    // Directed table, back to back.
    for (int i = 0; i < N_TBL; i++) begin
      set_beat(tbl[i].sign, tbl[i].exp, tbl[i].frac, tbl[i].sticky, tbl[i].zero, tbl[i].nar);
      cur_exp  = tbl[i].want;
      in_valid = 1'b1;
      tick();
      check("tbl_accept", {7'b0, in_fire}, 8'd1);
    end
    in_valid = 1'b0;
    drain("tbl_drain");

    // Randomized stream with 50% backpressure.
    sent = 0;
    have = 1'b0;
    for (int cyc = 0; cyc < 3000 && (sent < N_RAND || exp_q.size() > 0); cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!have && sent < N_RAND) begin
        set_beat(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), FRAC_W'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 15) == 0));
        cur_exp = ref_encode(in_sign, in_exp, in_frac, in_sticky, in_zero, in_nar);
        have    = 1'b1;
      end
      in_valid = have;
      tick();
      if (in_fire) begin
        have = 1'b0;
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 8'(sent), 8'(N_RAND));
    check("rand_drained", 8'(exp_q.size()), 8'd0);

    // Reset with two beats in flight.
    set_beat(1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0);
    cur_exp  = 8'h60;
    in_valid = 1'b1;
    tick();
    set_beat(1'b1, 4'd6, 8'h00, 1'b0, 1'b0, 1'b0);
    cur_exp  = 8'hC0;
    tick();
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", {7'b0, out_valid}, 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {7'b0, out_valid}, 8'd0);
    check("async_reset_posit", out_posit, 8'h00);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    last_cur = 8'h00;
    cur_exp  = last_cur;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("post_reset_valid", {7'b0, out_valid}, 8'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
